// File: rtl/pkt_buf_ctrl.sv
// Packet buffer controller: stores flagged packets into a simple dual-port RAM
// by base address and streams them back out, with length checks on both sides.
module pkt_buf_ctrl #(
  parameter int DW        = 134,
  parameter int AW        = 11,
  parameter int MAX_WORDS = 32,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_data_wr,
  input  logic [AW-1:0] waddr,
  input  logic          waddr_wr,
  input  logic [AW-1:0] raddr,
  input  logic          raddr_wr,
  output logic [DW-1:0] out_data,
  output logic          out_data_wr,
  output logic          out_eop,
  output logic          wr_busy,
  output logic          rd_busy,
  output logic          wr_done,
  output logic          rd_done,
  output logic [CW-1:0] wr_len,
  output logic [CW-1:0] rd_len,
  output logic          wr_err,
  output logic          rd_err
);

  typedef enum logic [1:0] {
    FLAG_SINGLE = 2'b00,
    FLAG_HEAD   = 2'b01,
    FLAG_TAIL   = 2'b10,
    FLAG_BODY   = 2'b11
  } flag_e;

  typedef enum logic [1:0] {W_IDLE, W_FIRST, W_WRITE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DONE}  r_state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  logic [DW-1:0] mem [2**AW];
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_q;

  // NOTE: the storage array has no reset; packet contents survive rst_n and
  // a resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= in_data;
    ram_q <= mem[ram_raddr];
  end

  // ---------------------------------------------------------------- write side
  w_state_e      w_state, w_next;
  logic [AW-1:0] w_ptr;
  logic [CW-1:0] w_cnt, w_cnt_next;
  logic          w_done_next, w_err_next;
  flag_e         in_flag;

  assign in_flag   = flag_e'(in_data[DW-1:DW-2]);
  assign ram_waddr = w_ptr;
  assign wr_busy   = (w_state != W_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next      = w_state;
    w_cnt_next  = w_cnt;
    w_done_next = 1'b0;
    w_err_next  = 1'b0;
    ram_we      = 1'b0;
    unique case (w_state)
      W_IDLE: if (waddr_wr) w_next = W_FIRST;
      W_FIRST: if (in_data_wr) begin
        ram_we     = 1'b1;
        w_cnt_next = CW'(1);
        if (in_flag == FLAG_TAIL || in_flag == FLAG_SINGLE) begin
          w_done_next = 1'b1;
          w_next      = W_IDLE;
        end else begin
          w_next = W_WRITE;
        end
      end
      W_WRITE: if (in_data_wr) begin
        if (in_flag == FLAG_TAIL) begin
          ram_we      = 1'b1;
          w_cnt_next  = w_cnt + CW'(1);
          w_done_next = 1'b1;
          w_next      = W_IDLE;
        end else if (w_cnt == MAX_CNT) begin
          // A non-tail word past the limit is dropped and the packet abandoned.
          w_err_next = 1'b1;
          w_next     = W_IDLE;
        end else begin
          ram_we     = 1'b1;
          w_cnt_next = w_cnt + CW'(1);
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr   <= '0;
      w_cnt   <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      wr_len  <= '0;
    end else begin
      if (w_state == W_IDLE && waddr_wr) w_ptr <= waddr;
      else if (ram_we)                   w_ptr <= w_ptr + AW'(1);
      w_cnt   <= w_cnt_next;
      wr_done <= w_done_next;
      wr_err  <= w_err_next;
      wr_len  <= w_done_next ? w_cnt_next : '0;
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_e      r_state, r_next;
  logic [AW-1:0] r_ptr;
  logic [CW-1:0] r_cnt, r_cnt_next;
  logic          r_ovf, r_ovf_next;
  logic          out_wr_next, out_eop_next;
  flag_e         q_flag;

  assign q_flag    = flag_e'(ram_q[DW-1:DW-2]);
  // The read port follows raddr while idle so the first word is fetched in the
  // same cycle the strobe is sampled; afterwards it walks the pointer.
  assign ram_raddr = (r_state == R_IDLE) ? raddr : r_ptr;
  assign rd_busy   = (r_state != R_IDLE);
  assign rd_done   = (r_state == R_DONE);
  assign rd_len    = rd_done ? r_cnt : '0;
  assign rd_err    = rd_done & r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // In R_READ the RAM output always holds the word fetched one cycle earlier.
  always_comb begin
    r_next       = r_state;
    r_cnt_next   = r_cnt;
    r_ovf_next   = r_ovf;
    out_wr_next  = 1'b0;
    out_eop_next = 1'b0;
    unique case (r_state)
      R_IDLE: if (raddr_wr) begin
        r_next     = R_READ;
        r_cnt_next = '0;
        r_ovf_next = 1'b0;
      end
      R_READ: begin
        out_wr_next = 1'b1;
        r_cnt_next  = r_cnt + CW'(1);
        if (q_flag == FLAG_TAIL || q_flag == FLAG_SINGLE) begin
          out_eop_next = 1'b1;
          r_next       = R_DONE;
        end else if (r_cnt_next == MAX_CNT) begin
          out_eop_next = 1'b1;
          r_ovf_next   = 1'b1;
          r_next       = R_DONE;
        end
      end
      R_DONE:  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      out_data    <= '0;
      out_data_wr <= 1'b0;
      out_eop     <= 1'b0;
    end else begin
      r_ptr       <= ram_raddr + AW'(1);
      r_cnt       <= r_cnt_next;
      r_ovf       <= r_ovf_next;
      out_data    <= out_wr_next ? ram_q : '0;
      out_data_wr <= out_wr_next;
      out_eop     <= out_eop_next;
    end
  end

endmodule

// File: doc/pkt_buf_ctrl.md
PKT_BUF_CTRL -- requirements
Module: pkt_buf_ctrl

Interface
REQ-001 SHALL have parameter DW, default 134, packet word width; bits [DW-1:DW-2] are the flag: 01 head, 11 body, 10 tail, 00 single-word packet.
REQ-002 SHALL have parameter AW, default 11, buffer address width; depth is 2^AW words.
REQ-003 SHALL have parameter MAX_WORDS, default 32, maximum packet length in words; legal range is 1..2^AW.
REQ-004 SHALL have parameter CW, default 6, word-count width; CW SHALL satisfy 2^CW > MAX_WORDS.
REQ-005 SHALL have port clk, input, 1, clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port in_data, input, DW, write packet word.
REQ-008 SHALL have port in_data_wr, input, 1, in_data valid strobe.
REQ-009 SHALL have port waddr, input, AW, packet base address for writing.
REQ-010 SHALL have port waddr_wr, input, 1, waddr valid strobe.
REQ-011 SHALL have port raddr, input, AW, packet base address for reading.
REQ-012 SHALL have port raddr_wr, input, 1, raddr valid strobe.
REQ-013 SHALL have port out_data, output, DW, read packet word.
REQ-014 SHALL have port out_data_wr, output, 1, out_data valid strobe.
REQ-015 SHALL have port out_eop, output, 1, asserted with the last word of a read packet.
REQ-016 SHALL have port wr_busy / rd_busy, output, 1 each, the write / read side is mid-packet.
REQ-017 SHALL have port wr_done, rd_done, output, 1 each, single-cycle completion pulses.
REQ-018 SHALL have port wr_len, rd_len, output, CW each, word count; valid only while the matching done pulse is high.
REQ-019 SHALL have port wr_err, rd_err, output, 1 each, single-cycle length-overflow pulses.

Function
REQ-020 SHALL contain an internal simple dual-port RAM of 2^AW x DW with synchronous read, 1-cycle latency; a read and a write to the same address in the same cycle returns the old data.
REQ-021 Write FSM SHALL have states W_IDLE, W_FIRST, W_WRITE.
- W_IDLE: waddr_wr=1 latches waddr and moves to W_FIRST.
- W_FIRST: the first in_data_wr writes the word at the base address and sets the count to 1.
  - Tail or single flag on that word: go to W_IDLE, pulse wr_done with wr_len=1.
  - Otherwise: go to W_WRITE.
- W_WRITE: each in_data_wr writes at the previous address + 1; gaps in in_data_wr are allowed.
  - Tail flag: pulse wr_done with wr_len = total words, go to W_IDLE.
REQ-022 A write SHALL occur only in a cycle where in_data_wr=1; in_data with in_data_wr=0 SHALL be ignored in every state.
REQ-023 Addresses SHALL wrap modulo 2^AW on both the write and read sides.
REQ-024 waddr_wr SHALL be ignored outside W_IDLE; wr_busy SHALL be 1 in W_FIRST and W_WRITE.
REQ-025 Write length overflow: if a non-tail word would become word MAX_WORDS+1, that word SHALL NOT be written; pulse wr_err, return to W_IDLE, no wr_done.
REQ-026 Read FSM SHALL have states R_IDLE, R_READ, R_DONE.
- R_IDLE: raddr_wr=1 issues a RAM read at raddr in the same cycle and moves to R_READ.
- R_READ: issues one read per cycle at incrementing addresses.
  - Each RAM output word is registered to out_data with out_data_wr=1.
REQ-027 Read latency: the first out_data_wr SHALL be asserted exactly 2 cycles after the cycle in which raddr_wr is sampled; output SHALL be one word per cycle with no gaps.
REQ-028 Read termination:
- When a RAM output word carries the tail or single flag, it is output with out_eop=1.
- Reads stop and the FSM goes to R_DONE.
- The at most 2 speculative reads beyond the tail SHALL NOT appear on out_data_wr.
REQ-029 Read length overflow: if MAX_WORDS words are output with no tail, word MAX_WORDS SHALL carry out_eop=1 and rd_err SHALL pulse together with rd_done.
REQ-030 R_DONE SHALL last one cycle, pulse rd_done with rd_len = words output, then return to R_IDLE.
REQ-031 raddr_wr SHALL be ignored outside R_IDLE; rd_busy SHALL be 1 from R_READ through R_DONE.
REQ-032 Read and write sides SHALL run independently and concurrently; no ordering between them is enforced.
REQ-033 out_data SHALL be 0 whenever out_data_wr=0.

Reset
REQ-034 On rst_n=0, both FSMs SHALL go to idle and every output SHALL be 0, asynchronously.
REQ-035 RAM contents SHALL NOT be cleared by reset.
REQ-036 A reset mid-packet SHALL abandon that packet with no done or err pulse.

Verification
REQ-037 Write a 4-word packet (01,11,11,10) at 0x010 with gaps, then read 0x010 -> out_data_wr at t+2..t+5, out_eop on word 4, rd_done with rd_len=4, the 2 extra reads suppressed.
REQ-038 Write a single-word packet (flag 00) at 0x7FF, then read it -> wr_len=1, one output word with out_eop=1, rd_len=1.
REQ-039 Write a 3-word packet at 0x7FE -> words land at 0x7FE, 0x7FF, 0x000; a read at 0x7FE returns all 3 in order.
REQ-040 Write 33 non-tail words with MAX_WORDS=32 -> wr_err pulse on word 33, no wr_done, word 33 not written; then read the base -> 32 words output, out_eop on the 32nd, rd_err and rd_done with rd_len=32.
REQ-041 Pulse waddr_wr/raddr_wr while busy, read and write concurrently, and assert rst_n low mid-read -> stray strobes ignored, concurrent traffic correct, all outputs 0 immediately on reset, no done pulse, next read correct.
